// File: rtl/active_list_committer.sv
// Active-list commit/recovery controller: retires a done, fault-free prefix of the
// head entries each cycle and walks the tail back during recovery.
module active_list_committer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int WALK_WIDTH   = 2,
  parameter int ENTRY_NUM    = 64,
  localparam int CNT_W = $clog2(ENTRY_NUM + 1),
  localparam int PH_W  = $clog2(COMMIT_WIDTH + 1),
  localparam int PT_W  = $clog2(WALK_WIDTH + 1),
  localparam int FL_W  = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        validEntryNum,
  input  logic [COMMIT_WIDTH-1:0] headDone,
  input  logic [COMMIT_WIDTH-1:0] headFault,
  input  logic                    commitStall,
  input  logic                    toRecoveryPhase,
  input  logic [CNT_W-1:0]        recoveryEntryNum,
  output logic [PH_W-1:0]         popHeadNum,
  output logic [COMMIT_WIDTH-1:0] commitLane,
  output logic [PT_W-1:0]         popTailNum,
  output logic                    faultCommit,
  output logic [FL_W-1:0]         faultLane,
  output logic                    recoveryDone,
  output logic                    inRecovery,
  output logic [31:0]             retiredCount
);

  typedef enum logic [1:0] {
    COMMIT     = 2'd0,
    FAULT_WAIT = 2'd1,
    REC_LOAD   = 2'd2,
    REC_WALK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WW_C = CNT_W'(WALK_WIDTH);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic [31:0]             retired_q;

  logic [COMMIT_WIDTH-1:0] lane;
  logic [PH_W-1:0]         fault_k;
  logic                    prefix_ok;
  logic                    fault;
  logic [FL_W-1:0]         fault_lane;
  logic [PT_W-1:0]         pop_tail;
  logic                    rec_done;

  function automatic logic [PH_W-1:0] popcnt(input logic [COMMIT_WIDTH-1:0] v);
    logic [PH_W-1:0] c;
    c = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) c = c + PH_W'(v[i]);
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lane        = '0;
    fault_k     = '0;
    prefix_ok   = 1'b1;
    fault       = 1'b0;
    fault_lane  = '0;
    pop_tail    = '0;
    rec_done    = 1'b0;
    case (state_q)
      COMMIT: begin
        if (toRecoveryPhase) begin
          state_d = REC_LOAD;
        end else if (!commitStall) begin
          for (int i = 0; i < COMMIT_WIDTH; i++) begin
            prefix_ok = prefix_ok & headDone[i] & ~headFault[i] & (CNT_W'(i) < validEntryNum);
            lane[i]   = prefix_ok;
          end
          // The fault candidate is the first entry that did not retire.
          fault_k = popcnt(lane);
          for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if ((PH_W'(i) == fault_k) && (CNT_W'(i) < validEntryNum) &&
                headDone[i] && headFault[i]) begin
              fault      = 1'b1;
              fault_lane = FL_W'(i);
            end
          end
          if (fault) state_d = FAULT_WAIT;
        end
      end
      FAULT_WAIT: begin
        if (toRecoveryPhase) state_d = REC_LOAD;
      end
      REC_LOAD: begin
        remaining_d = recoveryEntryNum;
        if (recoveryEntryNum == '0) begin
          rec_done = 1'b1;
          state_d  = COMMIT;
        end else begin
          state_d = REC_WALK;
        end
      end
      REC_WALK: begin
        if (remaining_q <= WW_C) begin
          pop_tail    = PT_W'(remaining_q);
          remaining_d = '0;
          rec_done    = 1'b1;
          state_d     = COMMIT;
        end else begin
          pop_tail    = PT_W'(WALK_WIDTH);
          remaining_d = remaining_q - WW_C;
        end
      end
      default: state_d = COMMIT;
    endcase
  end

  // Outputs are squashed during the reset cycle itself.
  assign commitLane   = rst ? '0 : lane;
  assign popHeadNum   = rst ? '0 : popcnt(lane);
  assign popTailNum   = rst ? '0 : pop_tail;
  assign faultCommit  = rst ? 1'b0 : fault;
  assign faultLane    = rst ? '0 : fault_lane;
  assign recoveryDone = rst ? 1'b0 : rec_done;
  assign inRecovery   = rst ? 1'b0 : (state_q != COMMIT);
  assign retiredCount = retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COMMIT;
      remaining_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      retired_q   <= retired_q + 32'(popHeadNum);
    end
  end

endmodule
